intra4x4_mode_select: RTL

Encoder-side counterpart of the intra reconstruction block: takes one 4x4 block of source luma pixels plus its top and left neighbour pixels. It evaluates the Vertical, Horizontal and DC 4x4 intra predictors by SAD and picks the cheapest mode. It then streams the 16 signed residues and the chosen mode to the transform/entropy stage and to the frame-level residue/mode stores that reconstruction reads back.

---
 rtl/intra4x4_mode_select.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/intra4x4_mode_select.sv
// Purpose : encoder-side 4x4 luma intra mode decision (Vertical/Horizontal/DC by SAD) with residue streaming.
// Latency : with gapless beats, DECIDE 1 cycle after the 16th beat and residues on the 16 cycles after that; done on the last residue.
// Backpressure: none; pix_valid gaps stall LOAD only, EMIT always runs 16 consecutive cycles.
//
// Ports:
//   clk, reset (async, active-low)
//   start, top_pix[31:0], left_pix[31:0], top_avail, left_avail : block setup, sampled in IDLE
//   pix_valid, pix_in[7:0] : source pixels in raster order
//   busy, mode[1:0], res_valid, res_out[8:0], done : status, decision and residue stream
module intra4x4_mode_select (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] top_pix,
  input  logic [31:0] left_pix,
  input  logic        top_avail,
  input  logic        left_avail,
  input  logic        pix_valid,
  input  logic [7:0]  pix_in,
  output logic        busy,
  output logic [1:0]  mode,
  output logic        res_valid,
  output logic [8:0]  res_out,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DECIDE, S_EMIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] top_q, top_d;
  logic [31:0] left_q, left_d;
  logic        tav_q, tav_d;
  logic        lav_q, lav_d;
  logic [11:0] sadv_q, sadv_d;
  logic [11:0] sadh_q, sadh_d;
  logic [11:0] sadd_q, sadd_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  buf_q [16];

  function automatic logic [7:0] pick8(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // DC predictor from the latched neighbours.
  logic [9:0]  sum_top, sum_left;
  logic [10:0] sum_all;
  logic [9:0]  sum_one;
  logic [7:0]  dc_pred;

  assign sum_top  = {2'b00, top_q[7:0]}   + {2'b00, top_q[15:8]}
                  + {2'b00, top_q[23:16]} + {2'b00, top_q[31:24]};
  assign sum_left = {2'b00, left_q[7:0]}   + {2'b00, left_q[15:8]}
                  + {2'b00, left_q[23:16]} + {2'b00, left_q[31:24]};
  assign sum_all  = {1'b0, sum_top} + {1'b0, sum_left} + 11'd4;

  always_comb begin
    dc_pred = 8'd128;
    sum_one = 10'd0;
    case ({tav_q, lav_q})
      2'b11: dc_pred = sum_all[10:3];
      2'b10: begin
        sum_one = sum_top + 10'd2;
        dc_pred = sum_one[9:2];
      end
      2'b01: begin
        sum_one = sum_left + 10'd2;
        dc_pred = sum_one[9:2];
      end
      default: dc_pred = 8'd128;
    endcase
  end

  // Mode decision: start from DC and let H then V displace it on <=,
  // which hands ties to the lower mode number.
  logic [1:0]  best_mode;
  logic [11:0] best_sad;

  always_comb begin
    best_mode = 2'd2;
    best_sad  = sadd_q;
    if (lav_q && (sadh_q <= best_sad)) begin
      best_mode = 2'd1;
      best_sad  = sadh_q;
    end
    if (tav_q && (sadv_q <= best_sad)) begin
      best_mode = 2'd0;
      best_sad  = sadv_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    top_d   = top_q;
    left_d  = left_q;
    tav_d   = tav_q;
    lav_d   = lav_q;
    sadv_d  = sadv_q;
    sadh_d  = sadh_q;
    sadd_d  = sadd_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          top_d   = top_pix;
          left_d  = left_pix;
          tav_d   = top_avail;
          lav_d   = left_avail;
          cnt_d   = 4'd0;
          sadv_d  = 12'd0;
          sadh_d  = 12'd0;
          sadd_d  = 12'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (pix_valid) begin
          sadv_d = sadv_q + {4'd0, absdiff(pix_in, pick8(top_q, cnt_q[1:0]))};
          sadh_d = sadh_q + {4'd0, absdiff(pix_in, pick8(left_q, cnt_q[3:2]))};
          sadd_d = sadd_q + {4'd0, absdiff(pix_in, dc_pred)};
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        mode_d  = best_mode;
        cnt_d   = 4'd0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      top_q   <= 32'd0;
      left_q  <= 32'd0;
      tav_q   <= 1'b0;
      lav_q   <= 1'b0;
      sadv_q  <= 12'd0;
      sadh_q  <= 12'd0;
      sadd_q  <= 12'd0;
      mode_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      left_q  <= left_d;
      tav_q   <= tav_d;
      lav_q   <= lav_d;
      sadv_q  <= sadv_d;
      sadh_q  <= sadh_d;
      sadd_q  <= sadd_d;
      mode_q  <= mode_d;
    end
  end

  // Pixel buffer needs no reset: it is fully rewritten before every EMIT.
  always_ff @(posedge clk) begin
    if ((state_q == S_LOAD) && pix_valid) buf_q[cnt_q] <= pix_in;
  end

  // Residue path.
  logic [7:0] pred_emit;

  always_comb begin
    case (mode_q)
      2'd0:    pred_emit = pick8(top_q, cnt_q[1:0]);
      2'd1:    pred_emit = pick8(left_q, cnt_q[3:2]);
      default: pred_emit = dc_pred;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign mode      = mode_q;
  assign res_valid = (state_q == S_EMIT);
  assign res_out   = res_valid ? ({1'b0, buf_q[cnt_q]} - {1'b0, pred_emit}) : 9'd0;
  assign done      = res_valid && (cnt_q == 4'd15);

endmodule
